// File: rtl/obs_mult_seq_30bit.sv
// Sequenced N x N carry-less polynomial multiplier: one shared N/2 x N/2 core
// computes the four even/odd sub-products, which are then interleaved into a 2N-1 bit product.
module obs_mult_seq_30bit #(
    parameter int N = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-2:0]   res_out,
    output logic             busy
);

    localparam int H  = N / 2;
    localparam int PW = N - 1;
    localparam int RW = 2 * N - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_COMB = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0] p_q [4];
    logic [PW-1:0] p_d [4];
    logic [RW-1:0] res_q, res_d;

    logic [H-1:0]  ae, ao, be, bo;
    logic [H-1:0]  core_a, core_b;
    logic [PW-1:0] core_p;

    function automatic logic [PW-1:0] clmul_half(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < H; i++) begin
            if (y[i]) acc = acc ^ ({{(PW-H){1'b0}}, x} << i);
        end
        return acc;
    endfunction

    // Even sub-products land on even result bits; the odd cross terms fill the odd bits,
    // and Ao*Bo is shifted up by one even position (x^2).
    function automatic logic [RW-1:0] combine(input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                                              input logic [PW-1:0] p3, input logic [PW-1:0] p4);
        logic [RW-1:0] r;
        r = '0;
        r[0] = p1[0];
        for (int k = 1; k < PW; k++) r[2*k] = p1[k] ^ p4[k-1];
        for (int k = 0; k < PW; k++) r[2*k+1] = p2[k] ^ p3[k];
        r[RW-1] = p4[PW-1];
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < H; k++) begin
            ae[k] = a_q[2*k];
            ao[k] = a_q[2*k+1];
            be[k] = b_q[2*k];
            bo[k] = b_q[2*k+1];
        end
    end

    // Slot order 0..3 = Ae*Be, Ae*Bo, Ao*Be, Ao*Bo: idx[1] picks the A half, idx[0] the B half.
    assign core_a = idx_q[1] ? ao : ae;
    assign core_b = idx_q[0] ? bo : be;
    assign core_p = clmul_half(core_a, core_b);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d[idx_q] = core_p;
                idx_d      = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_COMB;
            end
            S_COMB: begin
                res_d   = combine(p_q[0], p_q[1], p_q[2], p_q[3]);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            for (int i = 0; i < 4; i++) p_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res_out   = res_q;

endmodule

// File: tb/tb_obs_mult_seq_30bit.sv
// Randomised bench for obs_mult_seq_30bit against a full-width shift/xor carry-less model,
// with a handshake scoreboard that catches dropped or duplicated results.
module tb_obs_mult_seq_30bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] a_in;
    logic [29:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [58:0] res_out;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int pushed = 0;
    logic [58:0] exp_q[$];

    obs_mult_seq_30bit #(.N(30)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_out   (res_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [58:0] clmul_ref(input logic [29:0] a, input logic [29:0] b);
        logic [58:0] r;
        r = '0;
        for (int i = 0; i < 30; i++) begin
            if (b[i]) r = r ^ ({29'd0, a} << i);
        end
        return r;
    endfunction

    // Inputs settle here, well clear of both clock edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // A transfer happens at the next rising edge when both are high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("hs_extra", 64'd1, 64'd0);
            else chk("hs_res", {5'd0, res_out}, {5'd0, exp_q.pop_front()});
        end
    end

    task automatic run_op(input logic [29:0] a, input logic [29:0] b, input int hold,
                          input bit early, input bit release_iv, output logic [58:0] got);
        int lat;
        logic [58:0] expv;
        logic [58:0] held;
        expv = clmul_ref(a, b);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        exp_q.push_back(expv);
        pushed++;
        out_ready = early;
        step();
        in_valid = 1'b0;
        a_in = $urandom();
        b_in = $urandom();
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'd5);
        chk("busy_done", {63'd0, busy}, 64'd1);
        chk("res", {5'd0, res_out}, {5'd0, expv});
        got = res_out;
        held = res_out;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                step();
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_res", {5'd0, res_out}, {5'd0, held});
                chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            end
            out_ready = 1'b1;
            in_valid  = release_iv;
        end
        step();
        chk("after_hs_valid", {63'd0, out_valid}, 64'd0);
        chk("after_hs_ready", {63'd0, in_ready}, 64'd1);
        chk("after_hs_res", {5'd0, res_out}, {5'd0, held});
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [58:0] r;
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        a_in      = $urandom();
        b_in      = $urandom();
        step();
        in_valid  = 1'($urandom_range(0, 1));
        a_in      = $urandom();
        step();
        chk("rst_res", {5'd0, res_out}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();

        run_op(30'h1, 30'h1, 0, 1'b0, 1'b0, r);
        chk("dir_1x1", {5'd0, r}, 64'h1);
        run_op(30'h3, 30'h3, 1, 1'b0, 1'b0, r);
        chk("dir_3x3", {5'd0, r}, 64'h5);
        run_op(30'h3FFFFFFF, 30'h3FFFFFFF, 0, 1'b1, 1'b0, r);
        chk("dir_square", {5'd0, r}, 64'h0555555555555555);
        run_op(30'h20000000, 30'h20000000, 2, 1'b0, 1'b1, r);
        chk("dir_top", {5'd0, r}, 64'h0400000000000000);
        run_op($urandom(), $urandom(), 10, 1'b0, 1'b1, r);

        // Abort an operation two edges into the multiply phase.
        in_valid = 1'b1;
        a_in = 30'h2AAAAAAA;
        b_in = 30'h15555555;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_res", {5'd0, res_out}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {63'd0, seen}, 64'd0);
        out_ready = 1'b0;
        run_op(30'h5, 30'h3, 0, 1'b0, 1'b0, r);
        chk("dir_5x3", {5'd0, r}, 64'hF);

        for (int n = 0; n < 1000; n++) begin
            run_op($urandom(), $urandom(), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), r);
        end

        step();
        chk("hs_count", 64'(hs_cnt), 64'(pushed));
        chk("hs_pending", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
